// File: rtl/buffer_reader.sv
// buffer_reader: pops 16-bit words from a buffer, captures each one and
// converts it to five BCD digits with a serial shift-add-3 engine. Parity,
// a wrapping word count and a sticky pop-timeout flag are kept alongside.
module buffer_reader #(
  parameter int HOLD_CYCLES = 4,
  parameter int TIMEOUT     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        buffer_empty,
  input  logic        data_valid,
  input  logic [15:0] data_in,
  output logic        rd_en,
  output logic [15:0] data_out,
  output logic [19:0] bcd,
  output logic        bcd_valid,
  output logic        parity,
  output logic [7:0]  word_count,
  output logic        timeout_err,
  output logic [2:0]  state
);

  localparam int CONV_CYCLES = 16;
  localparam int MAX_A = (TIMEOUT > HOLD_CYCLES) ? TIMEOUT : HOLD_CYCLES;
  localparam int MAXC  = (MAX_A > CONV_CYCLES) ? MAX_A : CONV_CYCLES;
  localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_POP  = 3'd1,
    S_WAIT = 3'd2,
    S_CONV = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t      state_q;
  logic [CW-1:0] cnt_q;
  logic        rd_en_q;
  logic [15:0] data_out_q;
  logic [19:0] bcd_q;
  logic        bcd_valid_q;
  logic        parity_q;
  logic [7:0]  word_count_q;
  logic        timeout_err_q;

  // Conversion shift registers. The partial BCD value never exceeds 32767
  // before the last shift, so the top digit is at most 3 and only its low
  // three bits need to be carried between steps.
  logic [15:0] bin_sh_q;
  logic [18:0] bcd_sh_q;
  logic [18:0] adj;
  logic [19:0] bcd_step_d;

  // One shift-add-3 step: correct every digit >= 5, then shift in the next
  // binary bit. Digit 4 can never reach 5, so it is left uncorrected.
  always_comb begin
    adj = bcd_sh_q;
    for (int i = 0; i < 4; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    bcd_step_d = {adj, bin_sh_q[15]};
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      rd_en_q       <= 1'b0;
      data_out_q    <= '0;
      bcd_q         <= '0;
      bcd_valid_q   <= 1'b0;
      parity_q      <= 1'b0;
      word_count_q  <= '0;
      timeout_err_q <= 1'b0;
      bin_sh_q      <= '0;
      bcd_sh_q      <= '0;
    end else begin
      rd_en_q     <= 1'b0;
      bcd_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (run && !buffer_empty) begin
            state_q <= S_POP;
            rd_en_q <= 1'b1;
          end
        end
        S_POP: begin
          state_q <= S_WAIT;
          cnt_q   <= '0;
        end
        S_WAIT: begin
          if (data_valid) begin
            data_out_q   <= data_in;
            parity_q     <= ^data_in;
            word_count_q <= word_count_q + 8'd1;
            bin_sh_q     <= data_in;
            bcd_sh_q     <= '0;
            cnt_q        <= '0;
            state_q      <= S_CONV;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            timeout_err_q <= 1'b1;
            cnt_q         <= '0;
            state_q       <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_CONV: begin
          bcd_sh_q <= bcd_step_d[18:0];
          bin_sh_q <= {bin_sh_q[14:0], 1'b0};
          if (cnt_q == CW'(CONV_CYCLES - 1)) begin
            bcd_q       <= bcd_step_d;
            bcd_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= S_HOLD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_en       = rd_en_q;
  assign data_out    = data_out_q;
  assign bcd         = bcd_q;
  assign bcd_valid   = bcd_valid_q;
  assign parity      = parity_q;
  assign word_count  = word_count_q;
  assign timeout_err = timeout_err_q;
  assign state       = state_q;

endmodule

// File: tb/tb_buffer_reader.sv
// Randomized bench for buffer_reader. Inputs are driven and outputs sampled
// on the falling edge; a transaction-level model tracks the expected word,
// parity, count, decimal digits and the sticky timeout flag.
module tb_buffer_reader;
  localparam int HOLD = 4;
  localparam int TMO  = 8;

  logic        clk = 1'b0;
  logic        rst, run, buffer_empty, data_valid;
  logic [15:0] data_in;
  logic        rd_en, bcd_valid, parity, timeout_err;
  logic [15:0] data_out;
  logic [19:0] bcd;
  logic [7:0]  word_count;
  logic [2:0]  state;

  buffer_reader #(.HOLD_CYCLES(HOLD), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .run(run), .buffer_empty(buffer_empty),
    .data_valid(data_valid), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .bcd(bcd), .bcd_valid(bcd_valid), .parity(parity),
    .word_count(word_count), .timeout_err(timeout_err), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model
  int          exp_cnt;
  logic [15:0] exp_data;
  logic        exp_par;
  logic [19:0] exp_bcd;
  logic        exp_tmo;

  int rd_pulses = 0;
  always @(negedge clk) if (rd_en === 1'b1) rd_pulses++;

  function automatic logic [19:0] to_bcd(input logic [15:0] v);
    int x;
    logic [19:0] r;
    x = int'(v);
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    exp_cnt = 0; exp_data = '0; exp_par = 1'b0; exp_bcd = '0; exp_tmo = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; data_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Wait for the pop pulse; optionally toggles data_valid with junk while
  // the block is outside WAIT (those must be ignored).
  task automatic wait_rd(output int n, input bit junk);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (rd_en === 1'b1 || n >= 200) break;
      if (junk) begin
        data_valid = ($urandom_range(0, 3) == 0);
        data_in    = 16'($urandom);
      end
    end
    data_valid = 1'b0;
  endtask

  // One full transaction: pop, answer after d cycles, check capture,
  // conversion latency, result and pulse width. Ends in the 2nd HOLD cycle.
  task automatic do_txn(input logic [15:0] w, input int d, input bit junk,
                        input int exp_gap, input bit drop_run);
    int n;
    int i;
    logic [19:0] old_bcd;
    wait_rd(n, junk);
    checks++;
    if (rd_en !== 1'b1) begin
      errors++; $display("FAIL rd_wait no pop within %0d cycles", n); return;
    end
    if (drop_run) run = 1'b0;
    if (exp_gap >= 0) begin
      checks++;
      if (n !== exp_gap) begin errors++; $display("FAIL pop_gap got %0d exp %0d", n, exp_gap); end
    end
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL pop_state got %0d exp 1", state); end
    repeat (d) @(negedge clk);
    checks++;
    if (rd_en !== 1'b0 || state !== 3'd2) begin
      errors++; $display("FAIL wait_phase rd_en %0b state %0d exp 0/2", rd_en, state);
    end
    data_valid = 1'b1; data_in = w;
    @(negedge clk);
    data_valid = 1'b0; data_in = 16'($urandom);
    old_bcd  = exp_bcd;
    exp_cnt  = (exp_cnt + 1) % 256;
    exp_data = w;
    exp_par  = ($countones(w) % 2) == 1;
    checks++;
    if (data_out !== exp_data || parity !== exp_par || word_count !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL capture got %h/%b/%0d exp %h/%b/%0d", data_out, parity, word_count,
               exp_data, exp_par, exp_cnt);
    end
    checks++;
    if (state !== 3'd3 || bcd !== old_bcd || timeout_err !== exp_tmo) begin
      errors++;
      $display("FAIL conv_start state %0d bcd %h tmo %b exp 3/%h/%b", state, bcd,
               timeout_err, old_bcd, exp_tmo);
    end
    i = 0;
    while (i < 40) begin
      if (junk) begin
        data_valid = ($urandom_range(0, 2) == 0);
        data_in    = 16'($urandom);
      end
      @(negedge clk);
      i++;
      if (bcd_valid === 1'b1) break;
    end
    data_valid = 1'b0;
    exp_bcd = to_bcd(w);
    checks++;
    if (i !== 16) begin errors++; $display("FAIL bcd_latency got %0d exp 16", i); end
    checks++;
    if (bcd !== exp_bcd || state !== 3'd4) begin
      errors++; $display("FAIL bcd_result got %h state %0d exp %h state 4", bcd, state, exp_bcd);
    end
    @(negedge clk);
    checks++;
    if (bcd_valid !== 1'b0 || data_out !== exp_data || word_count !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL after_conv bcd_valid %b data %h cnt %0d exp 0/%h/%0d", bcd_valid,
               data_out, word_count, exp_data, exp_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; buffer_empty = 1'b1; data_valid = 1'b0; data_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({state, rd_en, data_out, bcd, bcd_valid, parity, word_count, timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_vals state %0d rd %b data %h bcd %h bv %b par %b cnt %0d tmo %b exp all 0",
               state, rd_en, data_out, bcd, bcd_valid, parity, word_count, timeout_err);
    end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (rd_en !== 1'b0 || state !== 3'd0) begin
      errors++; $display("FAIL reset_release rd %b state %0d exp 0/0", rd_en, state);
    end
  endtask

  task automatic test_directed();
    run = 1'b1; buffer_empty = 1'b0;
    do_txn(16'h1234, 2, 1'b0, -1, 1'b0);
    checks++;
    if (bcd !== 20'h04660 || parity !== 1'b1 || word_count !== 8'd1) begin
      errors++; $display("FAIL vec_1234 got %h/%b/%0d exp 04660/1/1", bcd, parity, word_count);
    end
    do_txn(16'hFFFF, 1, 1'b0, HOLD, 1'b0);
    checks++;
    if (bcd !== 20'h65535 || parity !== 1'b0) begin
      errors++; $display("FAIL vec_ffff got %h/%b exp 65535/0", bcd, parity);
    end
    do_txn(16'h0000, TMO, 1'b0, HOLD, 1'b0);
    checks++;
    if (bcd !== 20'h00000 || parity !== 1'b0) begin
      errors++; $display("FAIL vec_0000 got %h/%b exp 00000/0", bcd, parity);
    end
  endtask

  task automatic test_empty();
    int bad;
    buffer_empty = 1'b1;
    repeat (HOLD + 3) @(negedge clk);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      data_valid = ($urandom_range(0, 1) == 1);
      data_in    = 16'($urandom);
      @(negedge clk);
      if (rd_en !== 1'b0 || state !== 3'd0) bad++;
    end
    data_valid = 1'b0;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL empty_idle bad cycles %0d exp 0", bad); end
    checks++;
    if (word_count !== 8'(exp_cnt) || data_out !== exp_data) begin
      errors++; $display("FAIL idle_valid cnt %0d data %h exp %0d/%h", word_count, data_out,
                         exp_cnt, exp_data);
    end
  endtask

  task automatic test_timeout();
    int n;
    int bad;
    buffer_empty = 1'b0;
    wait_rd(n, 1'b0);
    checks++;
    if (rd_en !== 1'b1) begin errors++; $display("FAIL tmo_pop no pop within %0d", n); return; end
    bad = 0;
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      if (state !== 3'd2 || timeout_err !== exp_tmo) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL tmo_wait bad cycles %0d exp 0", bad); end
    @(negedge clk);
    exp_tmo = 1'b1;
    checks++;
    if (state !== 3'd0 || timeout_err !== 1'b1 || word_count !== 8'(exp_cnt) ||
        data_out !== exp_data || bcd !== exp_bcd) begin
      errors++;
      $display("FAIL tmo_expire state %0d tmo %b cnt %0d data %h bcd %h exp 0/1/%0d/%h/%h",
               state, timeout_err, word_count, data_out, bcd, exp_cnt, exp_data, exp_bcd);
    end
    do_txn(16'($urandom), 3, 1'b0, -1, 1'b0);
    checks++;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %b exp 1", timeout_err); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 20; k++)
      do_txn(16'($urandom), $urandom_range(1, TMO), 1'b1, HOLD, 1'b0);
  endtask

  task automatic test_run_drop();
    int bad;
    do_txn(16'($urandom), 2, 1'b0, HOLD, 1'b1);
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (rd_en !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0 || state !== 3'd0) begin
      errors++; $display("FAIL run_drop extra pops %0d state %0d exp 0/0", bad, state);
    end
  endtask

  task automatic test_rst_conv();
    int n;
    int bad;
    run = 1'b1; buffer_empty = 1'b0;
    wait_rd(n, 1'b0);
    @(negedge clk);
    data_valid = 1'b1; data_in = 16'h1234;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1; run = 1'b0; buffer_empty = 1'b1;
    @(negedge clk);
    checks++;
    if ({state, rd_en, data_out, bcd, bcd_valid, parity, word_count, timeout_err} !== '0) begin
      errors++;
      $display("FAIL rst_conv state %0d data %h bcd %h cnt %0d tmo %b exp all 0",
               state, data_out, bcd, word_count, timeout_err);
    end
    rst = 1'b0; model_reset();
    data_valid = 1'b1; data_in = 16'h5555;
    @(negedge clk);
    data_valid = 1'b0;
    bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bcd_valid !== 1'b0 || word_count !== 8'd0 || data_out !== 16'h0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL rst_late_valid bad cycles %0d exp 0", bad); end
    run = 1'b1; buffer_empty = 1'b0;
    do_txn(16'($urandom), 1, 1'b0, -1, 1'b0);
  endtask

  task automatic test_wrap();
    int base;
    apply_reset();
    run = 1'b1; buffer_empty = 1'b0;
    base = rd_pulses;
    for (int k = 0; k < 256; k++)
      do_txn(16'($urandom), $urandom_range(1, 3), 1'b1, (k == 0) ? -1 : HOLD, 1'b0);
    buffer_empty = 1'b1;
    checks++;
    if (word_count !== 8'd0) begin errors++; $display("FAIL wrap_count got %0d exp 0", word_count); end
    checks++;
    if (rd_pulses - base !== 256) begin
      errors++; $display("FAIL wrap_pulses got %0d exp 256", rd_pulses - base);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_empty();
    test_timeout();
    test_back_to_back();
    test_run_drop();
    test_rst_conv();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/buffer_reader.md
BUFFER_READER -- requirements
Module: buffer_reader

Interface
REQ-001 Parameter: HOLD_CYCLES, 4, number of clk cycles each converted word is held before the next pop (min 1).
REQ-002 Parameter: TIMEOUT, 8, clk cycles allowed in WAIT for data_valid after a pop (min 1).
REQ-003 clk  input  1  read-side clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 run  input  1  permits new pops when high; a transaction already started always completes.
REQ-006 buffer_empty  input  1  buffer has no readable word.
REQ-007 data_valid  input  1  data_in carries a popped word this cycle.
REQ-008 data_in  input  16  popped word.
REQ-009 rd_en  output  1  pop request to buffer; single-cycle pulse.
REQ-010 data_out  output  16  last captured word.
REQ-011 bcd  output  20  five BCD digits of data_out, most-significant digit in [19:16].
REQ-012 bcd_valid  output  1  one-cycle pulse when bcd updates.
REQ-013 parity  output  1  XOR of all bits of data_out.
REQ-014 word_count  output  8  number of words captured, modulo 256.
REQ-015 timeout_err  output  1  sticky flag: a pop was not answered within TIMEOUT cycles.
REQ-016 state  output  3  current state encoding, for LED debug.

Function
REQ-017 States and encoding: IDLE=0, POP=1, WAIT=2, CONV=3, HOLD=4; codes 5-7 return to IDLE on the next edge.
REQ-018 IDLE: move to POP when run=1 and buffer_empty=0; otherwise stay in IDLE.
REQ-019 POP: rd_en=1 for exactly the one cycle spent in POP, then go unconditionally to WAIT; rd_en=0 in every other state.
REQ-020 WAIT, data_valid=1 on an edge, all on that edge:
- capture data_in into data_out
- update parity
- increment word_count
- load the conversion shift register
- go to CONV
REQ-021 WAIT, timeout: if data_valid is not seen within TIMEOUT cycles of WAIT, set timeout_err and go to IDLE; data_out, parity, word_count and bcd are left unchanged.
REQ-022 data_valid is ignored in IDLE, POP, CONV and HOLD; no capture and no count change.
REQ-023 CONV: sequential shift-add-3 binary-to-BCD, one bit per cycle, exactly 16 cycles in CONV.
REQ-024 End of CONV: on the edge ending the 16th CONV cycle, bcd takes the result, bcd_valid=1 for that one following cycle, and state goes to HOLD.
REQ-025 bcd holds its value until the next conversion completes; the range is 0x00000-0x65535.
REQ-026 HOLD: stay exactly HOLD_CYCLES cycles, then go to IDLE regardless of run.
REQ-027 Latency: from the capture edge in WAIT to bcd_valid is 16 cycles; minimum pop-to-pop spacing is 1+1+16+HOLD_CYCLES+1 cycles (POP, WAIT, CONV, HOLD, IDLE).
REQ-028 run deasserted in POP, WAIT, CONV or HOLD does not abort; the block finishes and then rests in IDLE.
REQ-029 word_count wraps from 255 to 0 without a flag.
REQ-030 buffer_empty is sampled only in IDLE; a change to 1 during any other state has no effect.
REQ-031 timeout_err clears only on rst.

Reset
REQ-032 With rst=1 at an edge, the following take these values and hold them while rst=1: state=IDLE, rd_en=0, data_out=0, bcd=0, bcd_valid=0, parity=0, word_count=0, timeout_err=0, internal counters=0.
REQ-033 rst asserted mid-transaction (any state) aborts it on that edge; a late data_valid after rst deassertion is ignored, because the block is then in IDLE.
REQ-034 The first pop after reset release needs run=1 and buffer_empty=0; rd_en is asserted no earlier than 1 cycle after the release edge.

Verification
REQ-035 run=1, buffer_empty=0, data_valid with data_in=0x1234 two cycles after rd_en -> data_out=0x1234, parity=1, word_count=1, bcd=0x04660 with a bcd_valid pulse 16 cycles after capture.
REQ-036 data_in=0xFFFF -> bcd=0x65535, parity=0; data_in=0x0000 -> bcd=0x00000, parity=0.
REQ-037 buffer_empty=1 with run=1 for 50 cycles -> rd_en never asserts, state stays 0.
REQ-038 Pop with no data_valid -> after TIMEOUT=8 WAIT cycles timeout_err=1, state=IDLE, word_count unchanged; the flag stays 1 through later successful pops.
REQ-039 256 consecutive words -> word_count returns to 0; rd_en pulses exactly 256 times, each 1 cycle wide.
REQ-040 rst pulsed during CONV of 0x1234 -> all outputs at reset values, no bcd_valid pulse follows, normal operation on the next pop.
